fir_out_fifo: RTL and testbench
===============================

Name: fir_out_fifo

Overview:
- Output buffer directly downstream of the FIR core.
- Captures each result the core pulses out as a valid/data pair. The core has no ready input, so every pulse must be accepted or flagged as lost.
- Presents the results as an AXI-stream master with backpressure and frame framing (tlast after a programmed sample count).
- Provides status (level, full/empty, sticky overflow, sticky done) for the AXI-lite status logic.

Parameters:
- pDATA_WIDTH, 32, sample width.
- DEPTH, 16, FIFO entries; power of 2, at least 2.
- LEN_WIDTH, 16, width of the frame-length configuration.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  in  1  one-cycle result pulse from the FIR core (sm_tvalid).
- in_data  in  pDATA_WIDTH  result data (sm_tdata).
- cfg_len  in  LEN_WIDTH  samples per output frame.
- cfg_load  in  1  pulse: latch cfg_len, flush FIFO, clear status.
- m_tvalid  out  1  output stream valid.
- m_tdata  out  pDATA_WIDTH  output stream data.
- m_tlast  out  1  last beat of frame.
- m_tready  in  1  downstream ready.
- level  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky: a sample was dropped.
- done  out  1  sticky: a tlast beat has transferred.

Behaviour:
- Reset (rst_n low at an edge):
  - wr_ptr, rd_ptr, beat counter, latched length: 0.
  - Outputs: level=0, empty=1, full=0, m_tvalid=0, m_tlast=0, overflow=0, done=0.
  - m_tdata: don't-care until m_tvalid.
  - Reset mid-frame discards all contents.
- Storage:
  - DEPTH x pDATA_WIDTH register array.
  - Pointers are $clog2(DEPTH)+1 bits (extra wrap bit).
  - full = (msb differ, low bits equal); empty = (pointers equal). Both wrap naturally.
- Push/pop rules:
  - pop = m_tvalid && m_tready.
  - push = in_valid && (!full || pop).
- Drop on full:
  - in_valid && full && !pop → sample dropped; overflow set the same edge.
  - overflow stays set until cfg_load or reset.
- Latency and ordering:
  - Sample pushed at edge k drives m_tvalid=1 and m_tdata after edge k (first-word fall-through, one cycle).
  - Strict FIFO order.
- Empty with in_valid: push only; no pop is possible because m_tvalid=0.
- Full with in_valid and pop in the same cycle: both happen; level stays DEPTH; no overflow.
- Stall stability: while m_tvalid && !m_tready, m_tdata and m_tlast hold stable.
- m_tvalid = !empty; no combinational path from m_tready to m_tvalid.
- Framing:
  - beat counter increments on each pop.
  - m_tlast = m_tvalid && (len != 0) && (beat_cnt == len-1).
  - On a pop with m_tlast: beat_cnt returns to 0 and done sets.
  - len == 0: tlast never asserts; beat_cnt wraps modulo 2^LEN_WIDTH.
- cfg_load (highest priority):
  - Same edge: len <= cfg_len; pointers, beat_cnt, overflow, done cleared.
  - Any push or pop in that cycle is ignored, including the in_valid sample.
- level = wr_ptr - rd_ptr.
- All status outputs are combinational from registers.

Optional Feature:
- Macro: FIR_OUT_FIFO_PEAK_EN.
- Defined:
  - Adds output port peak_level ($clog2(DEPTH)+1 bits).
  - peak_level is the maximum level observed since reset or cfg_load, updated the cycle after level rises.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: hold rst_n=0 for 2 edges while in_valid=1 → m_tvalid=0, empty=1, level=0, overflow=0, done=0; no sample stored.
- Framing: cfg_load with cfg_len=4; push 0x11,0x22,0x33,0x44 with m_tready=1 → same order out; m_tlast only with 0x44; done=1 after that beat; beat_cnt back to 0.
- Overflow: m_tready=0; push 17 samples 1..17 → level=16, full=1, overflow=1; drain yields 1..16; 17 never appears.
- Full push+pop: FIFO full; in_valid=1 and m_tready=1 in the same cycle → level stays 16, overflow stays 0, new sample appears after the existing 16.
- Backpressure: toggle m_tready 1,0,0,1 during an 8-sample stream → m_tdata/m_tlast constant while stalled; no duplicate or lost beats.
- Mid-stream cfg_load: cfg_load with 5 entries queued and overflow=1 → next cycle level=0, empty=1, overflow=0, done=0; with FIR_OUT_FIFO_PEAK_EN, peak_level=0.

Source files
------------

// File: rtl/fir_out_fifo.sv
// Output FIFO between the FIR core and an AXI-stream sink, with tlast framing and status flags.
// Optional peak occupancy tracking is enabled by defining FIR_OUT_FIFO_PEAK_EN.
module fir_out_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int DEPTH       = 16,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [pDATA_WIDTH-1:0]   in_data,
    input  logic [LEN_WIDTH-1:0]     cfg_len,
    input  logic                     cfg_load,
    output logic                     m_tvalid,
    output logic [pDATA_WIDTH-1:0]   m_tdata,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     done
`ifdef FIR_OUT_FIFO_PEAK_EN
    ,
    output logic [$clog2(DEPTH):0]   peak_level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [pDATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [LEN_WIDTH-1:0]   len;
    logic [LEN_WIDTH-1:0]   beat_cnt;
    logic                   overflow_q;
    logic                   done_q;
    logic                   push;
    logic                   pop;
    logic                   drop;

    // Extra wrap bit on the pointers distinguishes full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign overflow = overflow_q;
    assign done     = done_q;

    assign m_tvalid = !empty;
    assign m_tdata  = mem[rd_ptr[AW-1:0]];
    assign m_tlast  = m_tvalid && (len != '0) && (beat_cnt == len - LEN_WIDTH'(1));

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign pop  = m_tvalid && m_tready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            len        <= '0;
            beat_cnt   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else if (cfg_load) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            len        <= cfg_len;
            beat_cnt   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                if (m_tlast) begin
                    beat_cnt <= '0;
                    done_q   <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Sample storage carries no reset; its contents are qualified by the pointers.
    always_ff @(posedge clk) begin
        if (rst_n && !cfg_load && push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

`ifdef FIR_OUT_FIFO_PEAK_EN
    logic [PW-1:0] peak_q;

    always_ff @(posedge clk) begin
        if (!rst_n || cfg_load) begin
            peak_q <= '0;
        end else if (level > peak_q) begin
            peak_q <= level;
        end
    end

    assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_fir_out_fifo.sv
// Self-checking bench for fir_out_fifo: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_fir_out_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 16;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_load = 1'b0;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tready = 1'b0;
    logic [PW-1:0] level;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          done;
`ifdef FIR_OUT_FIFO_PEAK_EN
    logic [PW-1:0] peak_level;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    int            mlen  = 0;
    int            mbeat = 0;
    bit            movf  = 1'b0;
    bit            mdone = 1'b0;
    int            mpeak = 0;

    always #5 clk = ~clk;

    fir_out_fifo #(.pDATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .cfg_len(cfg_len), .cfg_load(cfg_load),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
        .level(level), .full(full), .empty(empty), .overflow(overflow), .done(done)
`ifdef FIR_OUT_FIFO_PEAK_EN
        , .peak_level(peak_level)
`endif
    );

    function automatic bit model_last();
        return (q.size() > 0) && (mlen != 0) && (mbeat == mlen - 1);
    endfunction

    function automatic logic [10:0] model_status();
        logic [PW-1:0] lv;
        lv = PW'(q.size());
        return {q.size() > 0, model_last(), q.size() == DEPTH, q.size() == 0, movf, mdone, lv};
    endfunction

    // Apply the effect of the coming clock edge to the model using the current inputs.
    function automatic void model_update();
        bit pop;
        bit tl;
        int lvl;
        if (!rst_n || cfg_load) begin
            q.delete();
            mlen  = rst_n ? int'(cfg_len) : 0;
            mbeat = 0;
            movf  = 1'b0;
            mdone = 1'b0;
            mpeak = 0;
            return;
        end
        lvl = q.size();
        if (lvl > mpeak) mpeak = lvl;
        pop = (lvl > 0) && m_tready;
        tl  = model_last();
        if (pop) begin
            void'(q.pop_front());
            if (tl) begin
                mbeat = 0;
                mdone = 1'b1;
            end else begin
                mbeat = (mbeat + 1) % (1 << LW);
            end
        end
        if (in_valid) begin
            if (lvl < DEPTH || pop) q.push_back(in_data);
            else movf = 1'b1;
        end
    endfunction

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int len);
        cfg_len  = LW'(len);
        cfg_load = 1'b1;
        in_valid = 1'b0;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = $urandom;
        step();
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        checks++;
        if ({m_tvalid, empty, level, overflow, done, full} !== {1'b0, 1'b1, PW'(0), 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got tvalid=%b empty=%b level=%0d ovf=%b done=%b full=%b",
                     m_tvalid, empty, level, overflow, done, full);
        end
        step();
        checks++;
        if (m_tvalid !== 1'b0 || level !== PW'(0)) begin
            errors++;
            $display("FAIL reset_nostore got tvalid=%b level=%0d want 0 0", m_tvalid, level);
        end
    endtask

    task automatic test_framing();
        logic [DW-1:0] vals[8] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
        int got = 0;
        do_load(4);
        m_tready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_valid = (i < 8);
            in_data  = (i < 8) ? vals[i] : '0;
            if (m_tvalid && got < 8) begin
                checks++;
                if (m_tdata !== vals[got] || m_tlast !== (got % 4 == 3)) begin
                    errors++;
                    $display("FAIL frame_beat%0d got data=%h last=%b want data=%h last=%b",
                             got, m_tdata, m_tlast, vals[got], got % 4 == 3);
                end
                if (got == 3) begin
                    step();
                    checks++;
                    if (done !== 1'b1) begin
                        errors++;
                        $display("FAIL frame_done got %b want 1", done);
                    end
                    got++;
                    continue;
                end
                got++;
            end
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 8 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL frame_count got beats=%0d tvalid=%b want 8 0", got, m_tvalid);
        end
    endtask

    task automatic fill(input int n, input int base);
        m_tready = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(base + i);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_overflow();
        do_load(0);
        fill(17, 1);
        checks++;
        if (level !== PW'(16) || full !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_state got level=%0d full=%b ovf=%b want 16 1 1", level, full, overflow);
        end
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== DW'(i + 1)) begin
                errors++;
                $display("FAIL ovf_drain%0d got v=%b data=%0d want 1 %0d", i, m_tvalid, m_tdata, i + 1);
            end
            step();
        end
        checks++;
        if (empty !== 1'b1 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_extra got empty=%b tvalid=%b want 1 0", empty, m_tvalid);
        end
    endtask

    task automatic test_full_push_pop();
        do_load(0);
        fill(16, 100);
        in_valid = 1'b1;
        in_data  = 200;
        m_tready = 1'b1;
        step();
        in_valid = 1'b0;
        m_tready = 1'b0;
        checks++;
        if (level !== PW'(16) || overflow !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL fullpp_state got level=%0d ovf=%b full=%b want 16 0 1", level, overflow, full);
        end
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (m_tdata !== ((i < 15) ? DW'(101 + i) : DW'(200))) begin
                errors++;
                $display("FAIL fullpp_drain%0d got %0d want %0d", i, m_tdata, (i < 15) ? 101 + i : 200);
            end
            step();
        end
        m_tready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit            pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit            stalled = 1'b0;
        logic [DW-1:0] held_d = '0;
        logic          held_l = 1'b0;
        int            got = 0;
        do_load(8);
        for (int i = 0; i < 40; i++) begin
            in_valid = (i < 8);
            in_data  = DW'(32'hA0 + i);
            m_tready = pat[i % 4];
            if (stalled) begin
                checks++;
                if (m_tdata !== held_d || m_tlast !== held_l) begin
                    errors++;
                    $display("FAIL bp_stall got %h/%b want %h/%b", m_tdata, m_tlast, held_d, held_l);
                end
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (m_tdata !== DW'(32'hA0 + got) || m_tlast !== (got == 7)) begin
                    errors++;
                    $display("FAIL bp_beat%0d got %h/%b want %h/%b", got, m_tdata, m_tlast, 32'hA0 + got, got == 7);
                end
                got++;
            end
            stalled = m_tvalid && !m_tready;
            held_d  = m_tdata;
            held_l  = m_tlast;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 8 || done !== 1'b1) begin
            errors++;
            $display("FAIL bp_count got beats=%0d done=%b want 8 1", got, done);
        end
    endtask

    task automatic test_cfg_flush();
        do_load(0);
        fill(17, 300);
        m_tready = 1'b1;
        for (int i = 0; i < 11; i++) step();
        m_tready = 1'b0;
        checks++;
        if (level !== PW'(5) || overflow !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre got level=%0d ovf=%b want 5 1", level, overflow);
        end
        cfg_len  = 3;
        cfg_load = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD;
        m_tready = 1'b1;
        step();
        cfg_load = 1'b0;
        in_valid = 1'b0;
        m_tready = 1'b0;
        checks++;
        if ({level, empty, overflow, done, m_tvalid} !== {PW'(0), 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL flush_post got level=%0d empty=%b ovf=%b done=%b tvalid=%b",
                     level, empty, overflow, done, m_tvalid);
        end
`ifdef FIR_OUT_FIFO_PEAK_EN
        checks++;
        if (peak_level !== PW'(0)) begin
            errors++;
            $display("FAIL flush_peak got %0d want 0", peak_level);
        end
`endif
    endtask

    task automatic test_random();
        do_load($urandom_range(1, 6));
        for (int i = 0; i < 600; i++) begin
            cfg_load = ($urandom_range(0, 99) == 0);
            cfg_len  = LW'($urandom_range(0, 6));
            in_valid = ($urandom_range(0, 99) < 60);
            in_data  = $urandom;
            m_tready = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 40 : 85));
            checks++;
            if ({m_tvalid, m_tlast, full, empty, overflow, done, level} !== model_status()) begin
                errors++;
                $display("FAIL rand_status cyc=%0d got %b want %b", i,
                         {m_tvalid, m_tlast, full, empty, overflow, done, level}, model_status());
            end
            if (q.size() > 0) begin
                checks++;
                if (m_tdata !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data cyc=%0d got %h want %h", i, m_tdata, q[0]);
                end
            end
`ifdef FIR_OUT_FIFO_PEAK_EN
            checks++;
            if (peak_level !== PW'(mpeak)) begin
                errors++;
                $display("FAIL rand_peak cyc=%0d got %0d want %0d", i, peak_level, mpeak);
            end
`endif
            step();
        end
        cfg_load = 1'b0;
        in_valid = 1'b0;
        m_tready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_framing();
        test_overflow();
        test_full_push_pop();
        test_backpressure();
        test_cfg_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
